debug_host_ctrl: RTL and testbench

Host-side counterpart of the MIPS debug unit's UART protocol, used on a second FPGA or in a loopback harness. Streams a program from a local ROM to the target and issues RUN or STEP. Reassembles the returned PC/register/memory dump into words. Sits on the byte interfaces of a uart_tx/uart_rx pair; it does not contain the UART itself.

---
 rtl/debug_host_ctrl_if.sv | 25 ++
 rtl/debug_host_ctrl.sv | 212 +++++++++++++++++++++
 tb/tb_debug_host_ctrl.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/debug_host_ctrl_if.sv
// Byte-level link between debug_host_ctrl and its uart_tx/uart_rx pair.
// master = host controller side, slave = UART side.
interface debug_host_ctrl_if;
  logic [7:0] tx_byte;
  logic       tx_start;
  logic       tx_done;
  logic [7:0] rx_byte;
  logic       rx_valid;

  modport master (
    output tx_byte,
    output tx_start,
    input  tx_done,
    input  rx_byte,
    input  rx_valid
  );

  modport slave (
    input  tx_byte,
    input  tx_start,
    output tx_done,
    output rx_byte,
    output rx_valid
  );
endinterface

// File: rtl/debug_host_ctrl.sv
// Host side of the MIPS debug UART protocol: streams a ROM program, issues RUN/STEP and
// reassembles the returned dump. Define DEBUG_HOST_CHECKSUM_EN to expect a trailing XOR byte.
module debug_host_ctrl #(
  parameter int unsigned           DATA_WIDTH     = 32,
  parameter int unsigned           ROM_ADDR_WIDTH = 8,
  parameter int unsigned           NREGS          = 32,
  parameter int unsigned           MEM_WORDS      = 32,
  parameter logic [DATA_WIDTH-1:0] HALT_WORD      = DATA_WIDTH'(32'hFC000000),
  parameter int unsigned           TIMEOUT_CYCLES = 1000000
) (
  input  logic                      i_clock,
  input  logic                      i_reset,
  input  logic                      i_cmd_valid,
  input  logic [1:0]                i_cmd,
  output logic [ROM_ADDR_WIDTH-1:0] o_rom_addr,
  input  logic [DATA_WIDTH-1:0]     i_rom_data,
  debug_host_ctrl_if.master         uart,
  output logic [DATA_WIDTH-1:0]     o_word,
  output logic                      o_word_valid,
  output logic [7:0]                o_word_index,
  output logic                      o_busy,
  output logic                      o_done,
  output logic                      o_error
);

  localparam int unsigned BYTES       = DATA_WIDTH / 8;
  localparam int unsigned BCW         = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int unsigned TOTAL_WORDS = 1 + NREGS + MEM_WORDS;
  localparam logic [1:0]  CmdLoad     = 2'b00;
  localparam logic [1:0]  CmdRsvd     = 2'b11;

  typedef enum logic [3:0] {
    StIdle, StTxCmd, StWaitCmd, StFetch, StTxWord, StWaitWord,
    StRxDump, StRxSum, StDone, StError
  } state_e;

  state_e                    state_q, state_d;
  logic [1:0]                cmd_q, cmd_d;
  logic [ROM_ADDR_WIDTH-1:0] rom_addr_q, rom_addr_d;
  logic [BCW-1:0]            byte_cnt_q, byte_cnt_d;
  logic [7:0]                word_idx_q, word_idx_d;
  logic [7:0]                out_idx_q, out_idx_d;
  logic [31:0]               tout_q, tout_d;
  logic [DATA_WIDTH-1:0]     word_q, word_d;
  logic                      word_valid_q, word_valid_d;
  logic [7:0]                xor_q, xor_d;
  logic [7:0]                tx_byte_q, tx_byte_d;
  logic                      error_q, error_d;
  logic                      done_q, done_d;
  logic                      tx_start;
  logic [7:0]                tx_byte;
  logic                      last_byte;
  logic [7:0]                rom_byte;

  assign last_byte = (byte_cnt_q == BCW'(BYTES - 1));
  // ROM output stays valid for the whole word because the address is held until its last byte.
  assign rom_byte  = i_rom_data[(DATA_WIDTH - 8 - 8 * int'(byte_cnt_q)) +: 8];

  always_comb begin
    state_d      = state_q;
    cmd_d        = cmd_q;
    rom_addr_d   = rom_addr_q;
    byte_cnt_d   = byte_cnt_q;
    word_idx_d   = word_idx_q;
    out_idx_d    = out_idx_q;
    tout_d       = '0;
    word_d       = word_q;
    word_valid_d = 1'b0;
    xor_d        = xor_q;
    tx_byte_d    = tx_byte_q;
    error_d      = error_q;
    done_d       = 1'b0;
    tx_start     = 1'b0;
    tx_byte      = tx_byte_q;

    case (state_q)
      StIdle: begin
        if (i_cmd_valid && (i_cmd != CmdRsvd)) begin
          cmd_d      = i_cmd;
          error_d    = 1'b0;
          rom_addr_d = '0;
          byte_cnt_d = '0;
          word_idx_d = '0;
          xor_d      = '0;
          tx_byte_d  = {6'b0, i_cmd} + 8'd1;
          state_d    = StTxCmd;
        end
      end
      StTxCmd: begin
        tx_start = 1'b1;
        state_d  = StWaitCmd;
      end
      StWaitCmd: begin
        if (uart.tx_done) state_d = (cmd_q == CmdLoad) ? StFetch : StRxDump;
      end
      StFetch: state_d = StTxWord;
      StTxWord: begin
        tx_start  = 1'b1;
        tx_byte   = rom_byte;
        tx_byte_d = rom_byte;
        state_d   = StWaitWord;
      end
      StWaitWord: begin
        if (uart.tx_done) begin
          if (last_byte) begin
            byte_cnt_d = '0;
            if (i_rom_data == HALT_WORD) begin
              state_d = StDone;
            end else if (&rom_addr_q) begin
              error_d = 1'b1;
              state_d = StIdle;
            end else begin
              rom_addr_d = rom_addr_q + 1'b1;
              state_d    = StFetch;
            end
          end else begin
            byte_cnt_d = byte_cnt_q + BCW'(1);
            state_d    = StTxWord;
          end
        end
      end
      StRxDump: begin
        if (uart.rx_valid) begin
          word_d     = (word_q << 8) | DATA_WIDTH'(uart.rx_byte);
          xor_d      = xor_q ^ uart.rx_byte;
          byte_cnt_d = byte_cnt_q + BCW'(1);
          if (last_byte) begin
            byte_cnt_d   = '0;
            word_valid_d = 1'b1;
            out_idx_d    = word_idx_q;
            word_idx_d   = word_idx_q + 8'd1;
            if (word_idx_q == 8'(TOTAL_WORDS - 1)) begin
`ifdef DEBUG_HOST_CHECKSUM_EN
              state_d = StRxSum;
`else
              state_d = StDone;
`endif
            end
          end
        end else if (tout_q == 32'(TIMEOUT_CYCLES - 1)) begin
          error_d = 1'b1;
          state_d = StError;
        end else begin
          tout_d = tout_q + 32'd1;
        end
      end
`ifdef DEBUG_HOST_CHECKSUM_EN
      StRxSum: begin
        if (uart.rx_valid) begin
          if (uart.rx_byte != xor_q) error_d = 1'b1;
          state_d = StDone;
        end else if (tout_q == 32'(TIMEOUT_CYCLES - 1)) begin
          error_d = 1'b1;
          state_d = StError;
        end else begin
          tout_d = tout_q + 32'd1;
        end
      end
`endif
      // Done is registered so it lands one cycle after the final word strobe.
      StDone: begin
        done_d  = 1'b1;
        state_d = StIdle;
      end
      StError: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q      <= StIdle;
      cmd_q        <= '0;
      rom_addr_q   <= '0;
      byte_cnt_q   <= '0;
      word_idx_q   <= '0;
      out_idx_q    <= '0;
      tout_q       <= '0;
      word_q       <= '0;
      word_valid_q <= 1'b0;
      xor_q        <= '0;
      tx_byte_q    <= '0;
      error_q      <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cmd_q        <= cmd_d;
      rom_addr_q   <= rom_addr_d;
      byte_cnt_q   <= byte_cnt_d;
      word_idx_q   <= word_idx_d;
      out_idx_q    <= out_idx_d;
      tout_q       <= tout_d;
      word_q       <= word_d;
      word_valid_q <= word_valid_d;
      xor_q        <= xor_d;
      tx_byte_q    <= tx_byte_d;
      error_q      <= error_d;
      done_q       <= done_d;
    end
  end

  assign o_rom_addr    = rom_addr_q;
  assign uart.tx_byte  = tx_byte;
  assign uart.tx_start = tx_start;
  assign o_word        = word_q;
  assign o_word_valid  = word_valid_q;
  assign o_word_index  = out_idx_q;
  assign o_busy        = (state_q != StIdle);
  assign o_done        = done_q;
  assign o_error       = error_q;

endmodule

// File: tb/tb_debug_host_ctrl.sv
// Directed bench for debug_host_ctrl: ROM load, STEP/RUN dumps, timeout, ROM wrap, mid-dump reset.
// The checksum scenario is built only when DEBUG_HOST_CHECKSUM_EN is defined.
module tb_debug_host_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic [1:0]  cmd;
  logic [1:0]  rom_addr;
  logic [31:0] rom_data;
  logic [31:0] word;
  logic        word_valid;
  logic [7:0]  word_index;
  logic        busy, done, error;
  logic [31:0] rom [4];

  int checks = 0;
  int failures = 0;
  logic [7:0]  tx_q [$];
  logic [31:0] wq [$];
  logic [7:0]  iq [$];
  int done_cnt = 0;
  int overlap = 0;
  int start_viol = 0;
  int tx_wait = 0;

  debug_host_ctrl_if u_if ();

  debug_host_ctrl #(
    .ROM_ADDR_WIDTH (2),
    .TIMEOUT_CYCLES (100)
  ) dut (
    .i_clock      (clk),
    .i_reset      (rst),
    .i_cmd_valid  (cmd_valid),
    .i_cmd        (cmd),
    .o_rom_addr   (rom_addr),
    .i_rom_data   (rom_data),
    .uart         (u_if),
    .o_word       (word),
    .o_word_valid (word_valid),
    .o_word_index (word_index),
    .o_busy       (busy),
    .o_done       (done),
    .o_error      (error)
  );

  always #5 clk = ~clk;

  // Synchronous ROM: data valid one cycle after the address.
  always @(posedge clk) rom_data <= rom[rom_addr];

  // uart_tx model: logs each started byte and answers with tx_done three cycles later.
  always @(posedge clk) begin
    if (rst) begin
      tx_wait      <= 0;
      u_if.tx_done <= 1'b0;
    end else begin
      u_if.tx_done <= 1'b0;
      if (u_if.tx_start) begin
        tx_q.push_back(u_if.tx_byte);
        if (tx_wait != 0) start_viol <= start_viol + 1;
        tx_wait <= 3;
      end else if (tx_wait == 1) begin
        u_if.tx_done <= 1'b1;
        tx_wait      <= 0;
      end else if (tx_wait != 0) begin
        tx_wait <= tx_wait - 1;
      end
    end
  end

  always @(negedge clk) begin
    if (word_valid) begin
      wq.push_back(word);
      iq.push_back(word_index);
      if (done) overlap <= overlap + 1;
    end
    if (done) done_cnt <= done_cnt + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish want finish before 50000 cycles");
    $fatal(1, "watchdog expired");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic issue(input logic [1:0] c);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd       = c;
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd       = 2'b00;
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    u_if.rx_byte  = b;
    u_if.rx_valid = 1'b1;
    @(negedge clk);
    u_if.rx_valid = 1'b0;
  endtask

  function automatic logic [31:0] dump_word(input int k);
    if (k == 0) return 32'h0000_0004;
    if (k <= 32) return 32'(k);
    return 32'h0;
  endfunction

  task automatic send_dump(input logic [7:0] sum_flip);
    logic [7:0]  x;
    logic [31:0] w;
    x = 8'h00;
    for (int k = 0; k < 65; k++) begin
      w = dump_word(k);
      for (int b = 3; b >= 0; b--) begin
        send_byte(w[8*b +: 8]);
        x = x ^ w[8*b +: 8];
      end
    end
`ifdef DEBUG_HOST_CHECKSUM_EN
    send_byte(x ^ sum_flip);
`endif
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; cmd_valid = 1'b0; cmd = 2'b00;
    u_if.rx_byte = 8'h00; u_if.rx_valid = 1'b0;
    tick(3);
    rst = 1'b0;
    tick(1);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b want 0", done); end
    checks++; if (error !== 1'b0) begin failures++; $display("FAIL reset_error: got %b want 0", error); end
    checks++; if (word_valid !== 1'b0) begin failures++; $display("FAIL reset_wvalid: got %b want 0", word_valid); end
    checks++; if (rom_addr !== 2'd0) begin failures++; $display("FAIL reset_rom_addr: got %0d want 0", rom_addr); end
    checks++; if (u_if.tx_start !== 1'b0) begin failures++; $display("FAIL reset_tx_start: got %b want 0", u_if.tx_start); end
    checks++; if (u_if.tx_byte !== 8'h00) begin failures++; $display("FAIL reset_tx_byte: got %h want 00", u_if.tx_byte); end
    checks++; if (word !== 32'h0) begin failures++; $display("FAIL reset_word: got %h want 0", word); end
    checks++; if (word_index !== 8'h00) begin failures++; $display("FAIL reset_index: got %h want 0", word_index); end
  endtask

  task automatic test_load;
    logic [7:0] exp [13];
    int b0, d0;
    bit ok;
    exp = '{8'h01, 8'h20, 8'h01, 8'h00, 8'h05, 8'h20, 8'h02, 8'h00, 8'h03,
            8'hFC, 8'h00, 8'h00, 8'h00};
    rom[0] = 32'h2001_0005; rom[1] = 32'h2002_0003; rom[2] = 32'hFC00_0000; rom[3] = 32'h0;
    b0 = tx_q.size(); d0 = done_cnt;
    issue(2'b00);
    tick(2);
    issue(2'b01);  // must be ignored while busy
    wait_idle(400, ok);
    tick(3);
    checks++; if (!ok) begin failures++; $display("FAIL load_idle: got busy=1 want busy=0"); end
    checks++; if (tx_q.size() - b0 !== 13) begin failures++; $display("FAIL load_nbytes: got %0d want 13", tx_q.size() - b0); end
    for (int i = 0; i < 13; i++) begin
      checks++;
      if (tx_q[b0 + i] !== exp[i]) begin
        failures++; $display("FAIL load_byte%0d: got %h want %h", i, tx_q[b0 + i], exp[i]);
      end
    end
    checks++; if (done_cnt - d0 !== 1) begin failures++; $display("FAIL load_done: got %0d want 1", done_cnt - d0); end
    checks++; if (rom_addr !== 2'd2) begin failures++; $display("FAIL load_rom_addr: got %0d want 2", rom_addr); end
    checks++; if (error !== 1'b0) begin failures++; $display("FAIL load_error: got %b want 0", error); end
    checks++; if (start_viol !== 0) begin failures++; $display("FAIL load_tx_protocol: got %0d want 0", start_viol); end
  endtask

  task automatic test_step;
    int b0, w0, d0, bad;
    bit ok;
    b0 = tx_q.size(); w0 = wq.size(); d0 = done_cnt;
    issue(2'b10);
    tick(8);
    send_dump(8'h00);
    wait_idle(200, ok);
    tick(3);
    checks++; if (tx_q[b0] !== 8'h03) begin failures++; $display("FAIL step_cmd: got %h want 03", tx_q[b0]); end
    checks++; if (!ok) begin failures++; $display("FAIL step_idle: got busy=1 want busy=0"); end
    checks++; if (wq.size() - w0 !== 65) begin failures++; $display("FAIL step_nwords: got %0d want 65", wq.size() - w0); end
    checks++; if (wq[w0] !== 32'h4) begin failures++; $display("FAIL step_pc: got %h want 00000004", wq[w0]); end
    checks++; if (iq[w0] !== 8'd0) begin failures++; $display("FAIL step_pc_idx: got %0d want 0", iq[w0]); end
    checks++; if (wq[w0 + 5] !== 32'h5) begin failures++; $display("FAIL step_w5: got %h want 00000005", wq[w0 + 5]); end
    checks++; if (iq[w0 + 5] !== 8'd5) begin failures++; $display("FAIL step_idx5: got %0d want 5", iq[w0 + 5]); end
    bad = 0;
    for (int k = 0; k < 65; k++)
      if ((wq[w0 + k] !== dump_word(k)) || (iq[w0 + k] !== 8'(k))) bad++;
    checks++; if (bad !== 0) begin failures++; $display("FAIL step_all_words: got %0d bad want 0", bad); end
    checks++; if (done_cnt - d0 !== 1) begin failures++; $display("FAIL step_done: got %0d want 1", done_cnt - d0); end
    checks++; if (overlap !== 0) begin failures++; $display("FAIL step_overlap: got %0d want 0", overlap); end
    checks++; if (error !== 1'b0) begin failures++; $display("FAIL step_error: got %b want 0", error); end
  endtask

  task automatic test_timeout;
    int b0, w0, d0, n;
    b0 = tx_q.size(); w0 = wq.size(); d0 = done_cnt;
    issue(2'b01);
    tick(8);
    for (int i = 0; i < 10; i++) send_byte(8'hA0 + 8'(i));
    n = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      n++;
      if (error) break;
    end
    checks++; if (n !== 100) begin failures++; $display("FAIL timeout_cycles: got %0d want 100", n); end
    checks++; if (tx_q[b0] !== 8'h02) begin failures++; $display("FAIL run_cmd: got %h want 02", tx_q[b0]); end
    checks++; if (wq.size() - w0 !== 2) begin failures++; $display("FAIL timeout_nwords: got %0d want 2", wq.size() - w0); end
    checks++; if (wq[w0] !== 32'hA0A1A2A3) begin failures++; $display("FAIL timeout_word0: got %h want a0a1a2a3", wq[w0]); end
    tick(2);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL timeout_idle: got %b want 0", busy); end
    send_byte(8'h55);  // dropped while idle
    tick(2);
    checks++; if (wq.size() - w0 !== 2) begin failures++; $display("FAIL idle_drop: got %0d want 2", wq.size() - w0); end
    checks++; if (done_cnt - d0 !== 0) begin failures++; $display("FAIL timeout_done: got %0d want 0", done_cnt - d0); end
    checks++; if (error !== 1'b1) begin failures++; $display("FAIL timeout_sticky: got %b want 1", error); end
  endtask

  task automatic test_wrap;
    int b0, d0;
    bit ok;
    rom[0] = 32'h1111_1111; rom[1] = 32'h2222_2222; rom[2] = 32'h3333_3333; rom[3] = 32'h4444_4444;
    b0 = tx_q.size(); d0 = done_cnt;
    issue(2'b00);
    tick(1);
    checks++; if (error !== 1'b0) begin failures++; $display("FAIL wrap_err_clear: got %b want 0", error); end
    wait_idle(400, ok);
    tick(3);
    checks++; if (!ok) begin failures++; $display("FAIL wrap_idle: got busy=1 want busy=0"); end
    checks++; if (tx_q.size() - b0 !== 17) begin failures++; $display("FAIL wrap_nbytes: got %0d want 17", tx_q.size() - b0); end
    checks++; if (tx_q[b0 + 13] !== 8'h44) begin failures++; $display("FAIL wrap_last_word: got %h want 44", tx_q[b0 + 13]); end
    checks++; if (error !== 1'b1) begin failures++; $display("FAIL wrap_error: got %b want 1", error); end
    checks++; if (done_cnt - d0 !== 0) begin failures++; $display("FAIL wrap_done: got %0d want 0", done_cnt - d0); end
    checks++; if (rom_addr !== 2'd3) begin failures++; $display("FAIL wrap_rom_addr: got %0d want 3", rom_addr); end
  endtask

  task automatic test_reset_mid;
    int w0, d0;
    bit ok;
    d0 = done_cnt;
    issue(2'b10);
    tick(8);
    for (int i = 0; i < 6; i++) send_byte(8'hE0 + 8'(i));
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    tick(1);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rmid_busy: got %b want 0", busy); end
    checks++; if (error !== 1'b0) begin failures++; $display("FAIL rmid_error: got %b want 0", error); end
    w0 = wq.size();
    issue(2'b10);
    tick(8);
    send_dump(8'h00);
    wait_idle(200, ok);
    tick(3);
    checks++; if (!ok) begin failures++; $display("FAIL rmid_idle: got busy=1 want busy=0"); end
    checks++; if (wq[w0] !== 32'h4) begin failures++; $display("FAIL rmid_first_word: got %h want 00000004", wq[w0]); end
    checks++; if (iq[w0] !== 8'd0) begin failures++; $display("FAIL rmid_first_idx: got %0d want 0", iq[w0]); end
    checks++; if (wq.size() - w0 !== 65) begin failures++; $display("FAIL rmid_nwords: got %0d want 65", wq.size() - w0); end
    checks++; if (done_cnt - d0 !== 1) begin failures++; $display("FAIL rmid_done: got %0d want 1", done_cnt - d0); end
  endtask

`ifdef DEBUG_HOST_CHECKSUM_EN
  task automatic test_checksum;
    int d0;
    bit ok;
    d0 = done_cnt;
    issue(2'b10);
    tick(8);
    send_dump(8'h01);
    wait_idle(200, ok);
    tick(3);
    checks++; if (error !== 1'b1) begin failures++; $display("FAIL sum_bad_error: got %b want 1", error); end
    checks++; if (done_cnt - d0 !== 1) begin failures++; $display("FAIL sum_bad_done: got %0d want 1", done_cnt - d0); end
    d0 = done_cnt;
    issue(2'b10);
    tick(8);
    send_dump(8'h00);
    wait_idle(200, ok);
    tick(3);
    checks++; if (error !== 1'b0) begin failures++; $display("FAIL sum_good_error: got %b want 0", error); end
    checks++; if (done_cnt - d0 !== 1) begin failures++; $display("FAIL sum_good_done: got %0d want 1", done_cnt - d0); end
  endtask
`endif

  initial begin
    rom[0] = 32'h0; rom[1] = 32'h0; rom[2] = 32'h0; rom[3] = 32'h0;
    test_reset();
    test_load();
    test_step();
    test_timeout();
    test_wrap();
    test_reset_mid();
`ifdef DEBUG_HOST_CHECKSUM_EN
    test_checksum();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
